id_ex_stage: RTL and testbench

//  ID->EX pipeline register feeding the ALU a/b/op inputs, with operand forwarding.
//  - Latches the decoded instruction (op, operands, immediate, destination).
//  - Resolves RAW hazards by forwarding EX/MEM and MEM/WB results onto ex_a/ex_b.
//  - Supports stall (hold) and flush (bubble) from hazard/branch control.

---
 rtl/id_ex_stage.sv | 119 +++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Holds the decoded instruction for one cycle, resolves RAW hazards onto the
// ALU operand outputs, and honours stall (hold) and flush (bubble) requests.
module id_ex_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [2:0]       id_op,
    input  logic [ASIZE-1:0] id_rs1_addr,
    input  logic [ASIZE-1:0] id_rs2_addr,
    input  logic [DSIZE-1:0] id_rs1_data,
    input  logic [DSIZE-1:0] id_rs2_data,
    input  logic [DSIZE-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic [ASIZE-1:0] id_rd_addr,
    input  logic             id_wen,
    input  logic             exm_wen,
    input  logic [ASIZE-1:0] exm_rd_addr,
    input  logic [DSIZE-1:0] exm_result,
    input  logic             wb_wen,
    input  logic [ASIZE-1:0] wb_rd_addr,
    input  logic [DSIZE-1:0] wb_result,
    output logic             ex_valid,
    output logic [2:0]       ex_op,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [ASIZE-1:0] ex_rd_addr,
    output logic             ex_wen
);

    logic             valid_q;
    logic [2:0]       op_q;
    logic [ASIZE-1:0] rs1_q;
    logic [ASIZE-1:0] rs2_q;
    logic [DSIZE-1:0] a_q;
    logic [DSIZE-1:0] b_q;
    logic [DSIZE-1:0] imm_q;
    logic             use_imm_q;
    logic [ASIZE-1:0] rd_q;
    logic             wen_q;

    logic [DSIZE-1:0] fwd_a;
    logic [DSIZE-1:0] fwd_b;

    // Forwarding muxes: EX/MEM (younger) beats MEM/WB; register 0 never forwards.
    always_comb begin
        fwd_a = a_q;
        if (exm_wen && (exm_rd_addr == rs1_q) && (rs1_q != '0)) begin
            fwd_a = exm_result;
        end else if (wb_wen && (wb_rd_addr == rs1_q) && (rs1_q != '0)) begin
            fwd_a = wb_result;
        end

        fwd_b = b_q;
        if (exm_wen && (exm_rd_addr == rs2_q) && (rs2_q != '0)) begin
            fwd_b = exm_result;
        end else if (wb_wen && (wb_rd_addr == rs2_q) && (rs2_q != '0)) begin
            fwd_b = wb_result;
        end
    end

    // Pipeline register: flush beats stall beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
        end else if (stall) begin
            // Absorb forwarded values so a producer retiring during the stall is not lost.
            a_q <= fwd_a;
            b_q <= fwd_b;
        end else begin
            valid_q   <= id_valid;
            op_q      <= id_op;
            rs1_q     <= id_rs1_addr;
            rs2_q     <= id_rs2_addr;
            a_q       <= id_rs1_data;
            b_q       <= id_rs2_data;
            imm_q     <= id_imm;
            use_imm_q <= id_use_imm;
            rd_q      <= id_rd_addr;
            wen_q     <= id_wen & id_valid;
        end
    end

    // Output drive; immediate replaces rs2 entirely when selected.
    always_comb begin
        ex_valid   = valid_q;
        ex_op      = op_q;
        ex_a       = fwd_a;
        ex_b       = use_imm_q ? imm_q : fwd_b;
        ex_rd_addr = rd_q;
        ex_wen     = wen_q & valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic, all
// compared against a transaction-level model of the EX slot.
module tb_id_ex_stage;

    localparam int DSIZE = 16;
    localparam int ASIZE = 4;
    localparam logic [2:0] OP_ADD = 3'd0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, flush, id_valid, id_use_imm, id_wen;
    logic [2:0]       id_op;
    logic [ASIZE-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [DSIZE-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic             exm_wen, wb_wen;
    logic [ASIZE-1:0] exm_rd_addr, wb_rd_addr;
    logic [DSIZE-1:0] exm_result, wb_result;
    logic             ex_valid, ex_wen;
    logic [2:0]       ex_op;
    logic [DSIZE-1:0] ex_a, ex_b;
    logic [ASIZE-1:0] ex_rd_addr;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_op(id_op),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd_addr(id_rd_addr), .id_wen(id_wen),
        .exm_wen(exm_wen), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .wb_wen(wb_wen), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_rd_addr(ex_rd_addr), .ex_wen(ex_wen)
    );

    always #5 clk = ~clk;

    // Model of the instruction sitting in the EX slot.
    typedef struct {
        logic             valid;
        logic [2:0]       op;
        logic [ASIZE-1:0] src1, src2, rd;
        logic [DSIZE-1:0] val1, val2, imm;
        logic             use_imm, wen;
    } slot_t;

    slot_t m;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.op = 0; s.src1 = 0; s.src2 = 0; s.rd = 0;
        s.val1 = 0; s.val2 = 0; s.imm = 0; s.use_imm = 0; s.wen = 0;
        return s;
    endfunction

    // Value of register src as seen now, given the in-flight producers.
    function automatic logic [DSIZE-1:0] operand(logic [ASIZE-1:0] src, logic [DSIZE-1:0] latched);
        if (src == 0) return latched;
        if (exm_wen && exm_rd_addr == src) return exm_result;
        if (wb_wen && wb_rd_addr == src) return wb_result;
        return latched;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_model(string tag);
        #1;
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ".op"}, 32'(ex_op), 32'(m.op));
        chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(m.rd));
        chk({tag, ".wen"}, 32'(ex_wen), 32'(m.wen & m.valid));
        chk({tag, ".a"}, 32'(ex_a), 32'(operand(m.src1, m.val1)));
        chk({tag, ".b"}, 32'(ex_b), 32'(m.use_imm ? m.imm : operand(m.src2, m.val2)));
    endtask

    // Advance one clock, updating the model with the inputs the edge sees.
    task automatic clock_step();
        slot_t n;
        n = m;
        if (flush) begin
            n = empty_slot();
        end else if (stall) begin
            n.val1 = operand(m.src1, m.val1);
            n.val2 = operand(m.src2, m.val2);
        end else begin
            n.valid = id_valid; n.op = id_op; n.src1 = id_rs1_addr; n.src2 = id_rs2_addr;
            n.val1 = id_rs1_data; n.val2 = id_rs2_data; n.imm = id_imm;
            n.use_imm = id_use_imm; n.rd = id_rd_addr; n.wen = id_wen & id_valid;
        end
        @(posedge clk);
        m = n;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0; id_op = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0; id_rd_addr = 0;
        id_wen = 0; exm_wen = 0; exm_rd_addr = 0; exm_result = 0;
        wb_wen = 0; wb_rd_addr = 0; wb_result = 0;
    endtask

    task automatic issue(logic [2:0] op, logic [ASIZE-1:0] s1, logic [DSIZE-1:0] d1,
                         logic [ASIZE-1:0] s2, logic [DSIZE-1:0] d2,
                         logic [ASIZE-1:0] rd, logic wen);
        id_valid = 1; id_op = op; id_rs1_addr = s1; id_rs1_data = d1;
        id_rs2_addr = s2; id_rs2_data = d2; id_rd_addr = rd; id_wen = wen;
        id_use_imm = 0; id_imm = 0;
    endtask

    initial begin
        m = empty_slot();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check_model("reset");
        chk("reset.a0", 32'(ex_a), 32'h0);
        rst_n = 1;

        // 1. Pass-through
        issue(OP_ADD, 4'd1, 16'd5, 4'd4, 16'd3, 4'd2, 1'b1);
        clock_step();
        idle_inputs();
        check_model("pass");
        chk("pass.a", 32'(ex_a), 32'd5);
        chk("pass.b", 32'(ex_b), 32'd3);
        chk("pass.wen", 32'(ex_wen), 32'd1);

        // 2. Forward priority on src1=3
        issue(OP_ADD, 4'd3, 16'h0011, 4'd0, 16'h0, 4'd7, 1'b1);
        clock_step();
        idle_inputs();
        stall = 1;
        exm_wen = 1; exm_rd_addr = 3; exm_result = 16'h00AA;
        wb_wen = 1; wb_rd_addr = 3; wb_result = 16'h0055;
        check_model("fwd_both");
        chk("fwd_both.a", 32'(ex_a), 32'h00AA);
        exm_wen = 0;
        check_model("fwd_wb");
        chk("fwd_wb.a", 32'(ex_a), 32'h0055);
        wb_wen = 0;
        check_model("fwd_none");
        chk("fwd_none.a", 32'(ex_a), 32'h0011);
        stall = 0;

        // 3. Register zero never forwards
        issue(OP_ADD, 4'd0, 16'h0042, 4'd0, 16'h0, 4'd1, 1'b1);
        clock_step();
        idle_inputs();
        exm_wen = 1; exm_rd_addr = 0; exm_result = 16'hFFFF;
        check_model("r0");
        chk("r0.a", 32'(ex_a), 32'h0042);
        exm_wen = 0;

        // 4. Stall across retire of a producer to src2
        issue(OP_ADD, 4'd1, 16'h0001, 4'd5, 16'h1111, 4'd6, 1'b1);
        clock_step();
        idle_inputs();
        stall = 1; wb_wen = 1; wb_rd_addr = 5; wb_result = 16'h1234;
        check_model("stall_fwd");
        chk("stall_fwd.b", 32'(ex_b), 32'h1234);
        clock_step();
        wb_wen = 0;
        issue(OP_ADD, 4'd9, 16'hBEEF, 4'd10, 16'hCAFE, 4'd11, 1'b0);
        check_model("stall_hold");
        chk("stall_hold.b", 32'(ex_b), 32'h1234);
        chk("stall_hold.rd", 32'(ex_rd_addr), 32'd6);
        clock_step();
        idle_inputs();
        check_model("stall_held2");

        // 5. Flush beats stall; immediate not forwarded
        issue(OP_ADD, 4'd2, 16'h0002, 4'd3, 16'h0003, 4'd4, 1'b1);
        flush = 1; stall = 1;
        clock_step();
        idle_inputs();
        check_model("flush");
        chk("flush.valid", 32'(ex_valid), 32'd0);
        chk("flush.wen", 32'(ex_wen), 32'd0);
        issue(OP_ADD, 4'd1, 16'h0010, 4'd6, 16'h0020, 4'd8, 1'b1);
        id_use_imm = 1; id_imm = 16'd7;
        clock_step();
        idle_inputs();
        exm_wen = 1; exm_rd_addr = 6; exm_result = 16'h5555;
        check_model("imm");
        chk("imm.b", 32'(ex_b), 32'd7);
        exm_wen = 0;

        // 6. Asynchronous reset between edges
        issue(OP_ADD, 4'd3, 16'h00AA, 4'd0, 16'h0, 4'd3, 1'b1);
        clock_step();
        idle_inputs();
        check_model("pre_rst");
        chk("pre_rst.a", 32'(ex_a), 32'h00AA);
        #1 rst_n = 0;
        m = empty_slot();
        check_model("async_rst");
        chk("async_rst.a", 32'(ex_a), 32'h0);
        #1 rst_n = 1;
        issue(OP_ADD, 4'd1, 16'h0077, 4'd2, 16'h0088, 4'd9, 1'b1);
        clock_step();
        idle_inputs();
        check_model("post_rst");
        chk("post_rst.a", 32'(ex_a), 32'h0077);

        // Randomized traffic with narrow address range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            id_valid    = $urandom_range(0, 1);
            id_op       = 3'($urandom);
            id_rs1_addr = 4'($urandom_range(0, 3));
            id_rs2_addr = 4'($urandom_range(0, 3));
            id_rs1_data = 16'($urandom);
            id_rs2_data = 16'($urandom);
            id_imm      = 16'($urandom);
            id_use_imm  = ($urandom_range(0, 3) == 0);
            id_rd_addr  = 4'($urandom);
            id_wen      = $urandom_range(0, 1);
            exm_wen     = $urandom_range(0, 1);
            exm_rd_addr = 4'($urandom_range(0, 3));
            exm_result  = 16'($urandom);
            wb_wen      = $urandom_range(0, 1);
            wb_rd_addr  = 4'($urandom_range(0, 3));
            wb_result   = 16'($urandom);
            check_model("rand");
            clock_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
